// File: rtl/cp_s1_sample_packer.sv
// cp_s1_sample_packer
//   Packs a stream of SAMPLE_WIDTH-bit chirp samples into READ_RAM_WIDTH-bit RAM words
//   (lane 0 in the least significant bits) and issues one registered RAM write per word.
//   A chirp is armed by i_start. It ends on i_data_last or after DATA_NUM accepted samples.
//   A partial final word is flushed with its unused upper lanes zeroed.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : one-cycle pulse, (re)arms a chirp from any state
//   i_data          : input sample
//   i_data_valid    : i_data qualifier
//   i_data_last     : final sample of the chirp (qualified by i_data_valid)
//   o_m1_wr_data    : packed RAM write word (holds when not writing)
//   o_m1_wr_addr    : RAM write address (holds when not writing)
//   o_m1_wr_en      : RAM enable, one cycle per word
//   o_m1_wr_wea     : RAM write enable, identical to o_m1_wr_en
//   o_finish        : one-cycle pulse alongside the final write of a chirp
//   o_overflow      : sticky; samples arrived after a count-terminated chirp
module cp_s1_sample_packer #(
  parameter int unsigned SAMPLE_WIDTH   = 32,
  parameter int unsigned READ_RAM_WIDTH = 128,
  parameter int unsigned DATA_NUM       = 1024,
  parameter int unsigned INIT_ADDR      = 0,
  parameter int unsigned ADD_ADDR       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [SAMPLE_WIDTH-1:0]   i_data,
  input  logic                      i_data_valid,
  input  logic                      i_data_last,
  output logic [READ_RAM_WIDTH-1:0] o_m1_wr_data,
  output logic [31:0]               o_m1_wr_addr,
  output logic                      o_m1_wr_en,
  output logic                      o_m1_wr_wea,
  output logic                      o_finish,
  output logic                      o_overflow
);

  localparam int unsigned LANES  = READ_RAM_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_NUM + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    r_state;
  logic [LANE_W-1:0]         r_lane;
  logic [CNT_W-1:0]          r_cnt;
  logic [31:0]               r_addr;
  logic [READ_RAM_WIDTH-1:0] r_word;
  logic                      r_armed;   // last chirp ended on the sample count
  logic [READ_RAM_WIDTH-1:0] r_wr_data;
  logic [31:0]               r_wr_addr;
  logic                      r_wr_en;
  logic                      r_finish;
  logic                      r_overflow;

  // Effective chirp context for this cycle: i_start overrides the registered context so a
  // sample arriving with i_start lands in lane 0 of the new chirp.
  logic [LANE_W-1:0]         w_lane;
  logic [CNT_W-1:0]          w_cnt;
  logic [31:0]               w_addr;
  logic [READ_RAM_WIDTH-1:0] w_word;
  logic                      w_run;
  logic                      w_accept;
  logic [READ_RAM_WIDTH-1:0] w_word_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_final;
  logic                      w_emit;

  always_comb begin
    w_lane     = i_start ? '0 : r_lane;
    w_cnt      = i_start ? '0 : r_cnt;
    w_addr     = i_start ? INIT_ADDR : r_addr;
    w_word     = i_start ? '0 : r_word;
    w_run      = i_start | (r_state == StRun);
    w_accept   = w_run & i_data_valid;
    w_word_nxt = w_word;
    w_word_nxt[int'(w_lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = i_data;
    w_cnt_nxt  = w_cnt + CNT_W'(1);
    w_final    = i_data_last | (w_cnt_nxt == CNT_W'(DATA_NUM));
    // A last sample in lane LANES-1 is a single write, never an extra empty word.
    w_emit     = (w_lane == LANE_W'(LANES - 1)) | w_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_lane     <= '0;
      r_cnt      <= '0;
      r_addr     <= INIT_ADDR;
      r_word     <= '0;
      r_armed    <= 1'b0;
      r_wr_data  <= '0;
      r_wr_addr  <= INIT_ADDR;
      r_wr_en    <= 1'b0;
      r_finish   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_finish <= 1'b0;

      // Restart discards any partial word silently.
      if (i_start) begin
        r_state    <= StRun;
        r_lane     <= '0;
        r_cnt      <= '0;
        r_addr     <= INIT_ADDR;
        r_word     <= '0;
        r_armed    <= 1'b0;
        r_overflow <= 1'b0;
      end

      if (w_accept) begin
        r_cnt <= w_cnt_nxt;
        if (w_emit) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_word_nxt;
          r_wr_addr <= w_addr;
          r_addr    <= w_addr + ADD_ADDR;
          r_word    <= '0;
          r_lane    <= '0;
        end else begin
          r_word <= w_word_nxt;
          r_lane <= w_lane + LANE_W'(1);
        end
        if (w_final) begin
          r_state  <= StIdle;
          r_finish <= 1'b1;
          r_armed  <= ~i_data_last;
        end
      end else if (!w_run && i_data_valid && r_armed) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_m1_wr_data = r_wr_data;
  assign o_m1_wr_addr = r_wr_addr;
  assign o_m1_wr_en   = r_wr_en;
  assign o_m1_wr_wea  = r_wr_en;
  assign o_finish     = r_finish;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_cp_s1_sample_packer.sv
module tb_cp_s1_sample_packer;

  localparam int DATA_NUM = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [31:0]  i_data = '0;
  logic         i_data_valid = 1'b0;
  logic         i_data_last = 1'b0;
  logic [127:0] o_m1_wr_data;
  logic [31:0]  o_m1_wr_addr;
  logic         o_m1_wr_en;
  logic         o_m1_wr_wea;
  logic         o_finish;
  logic         o_overflow;

  cp_s1_sample_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_m1_wr_data (o_m1_wr_data),
    .o_m1_wr_addr (o_m1_wr_addr),
    .o_m1_wr_en   (o_m1_wr_en),
    .o_m1_wr_wea  (o_m1_wr_wea),
    .o_finish     (o_finish),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: samples of the current word kept in a queue, packed on emit.
  bit          m_run;
  logic [31:0] m_cur[$];
  int          m_cnt;
  logic [31:0] m_addr;
  bit          m_armed;
  logic [127:0] exp_data;
  logic [31:0]  exp_addr;
  logic         exp_en;
  logic         exp_fin;
  logic         exp_ovf;
  int           n_writes;

  task automatic model_reset();
    m_run = 0; m_cur.delete(); m_cnt = 0; m_addr = 0; m_armed = 0;
    exp_data = '0; exp_addr = 0; exp_en = 0; exp_fin = 0; exp_ovf = 0;
  endtask

  task automatic model_step(input bit st, input bit v, input bit l, input logic [31:0] d);
    bit fin;
    logic [127:0] w;
    exp_en = 0;
    exp_fin = 0;
    if (st) begin
      m_run = 1; m_cur.delete(); m_cnt = 0; m_addr = 0; m_armed = 0; exp_ovf = 0;
    end
    if (v && m_run) begin
      m_cur.push_back(d);
      m_cnt++;
      fin = l || (m_cnt == DATA_NUM);
      if (m_cur.size() == 4 || fin) begin
        w = '0;
        foreach (m_cur[i]) w[32*i +: 32] = m_cur[i];
        exp_data = w;
        exp_addr = m_addr;
        exp_en = 1;
        m_addr = m_addr + 32'd1;
        m_cur.delete();
        n_writes++;
      end
      if (fin) begin
        m_run = 0; exp_fin = 1; m_armed = !l;
      end
    end else if (v && m_armed) begin
      exp_ovf = 1;
    end
  endtask

  // Drive one cycle of stimulus, update the model at the edge, settle 1 time unit after.
  task automatic cycle(input bit st, input bit v, input bit l, input logic [31:0] d);
    i_start = st; i_data_valid = v; i_data_last = l; i_data = d;
    @(posedge clk);
    model_step(st, v, l, d);
    #1;
    i_start = 0; i_data_valid = 0; i_data_last = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !== {4'b0, 32'd0, 128'd0}) begin
      bad++;
      $display("FAIL reset_values got en=%b wea=%b fin=%b ovf=%b addr=%h data=%h required all zero",
               o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data);
    end
    rst_n = 1;
    // Idle samples with no prior chirp: no write, no overflow.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, (i == 3), 32'hA0 + i);
      total++;
      if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow} !== 4'b0) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d got en=%b wea=%b fin=%b ovf=%b required 0",
                 i, o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow);
      end
    end
  endtask

  task automatic test_basic();
    logic [127:0] k_words[4];
    int wi;
    k_words[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    k_words[1] = {32'd8, 32'd7, 32'd6, 32'd5};
    k_words[2] = {32'd4, 32'd3, 32'd2, 32'd1};
    k_words[3] = {32'd0, 32'd0, 32'd0, 32'd5};
    wi = 0;
    for (int c = 0; c < 2; c++) begin
      int n = (c == 0) ? 8 : 5;
      cycle(1, 0, 0, 0);
      for (int s = 1; s <= n; s++) begin
        cycle(0, 1, (s == n), s);
        total++;
        if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !==
            {exp_en, exp_en, exp_fin, exp_ovf, exp_addr, exp_data}) begin
          bad++;
          $display("FAIL basic c=%0d s=%0d got en=%b fin=%b ovf=%b addr=%h data=%h required en=%b fin=%b ovf=%b addr=%h data=%h",
                   c, s, o_m1_wr_en, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data,
                   exp_en, exp_fin, exp_ovf, exp_addr, exp_data);
        end
        if (o_m1_wr_en === 1'b1) begin
          total++;
          if (o_m1_wr_data !== k_words[wi] || o_m1_wr_addr !== 32'(wi % 2) ||
              o_finish !== (wi % 2 == 1)) begin
            bad++;
            $display("FAIL basic_const w=%0d got addr=%h data=%h fin=%b required addr=%h data=%h",
                     wi, o_m1_wr_addr, o_m1_wr_data, o_finish, wi % 2, k_words[wi]);
          end
          if (wi < 3) wi++;
        end
      end
      // Back in IDLE: further samples neither write nor flag overflow.
      cycle(0, 1, 0, 32'hDEAD);
      total++;
      if ({o_m1_wr_en, o_finish, o_overflow} !== 3'b0) begin
        bad++;
        $display("FAIL basic_idle c=%0d got en=%b fin=%b ovf=%b required 0",
                 c, o_m1_wr_en, o_finish, o_overflow);
      end
    end
  endtask

  task automatic test_full_chirp();
    logic [31:0] last_addr;
    bit fin_seen;
    n_writes = 0;
    last_addr = '1;
    fin_seen = 0;
    cycle(1, 0, 0, 0);
    for (int s = 0; s < DATA_NUM + 3; s++) begin
      cycle(0, 1, 0, $urandom);
      total++;
      if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !==
          {exp_en, exp_en, exp_fin, exp_ovf, exp_addr, exp_data}) begin
        bad++;
        $display("FAIL full_chirp s=%0d got en=%b fin=%b ovf=%b addr=%h data=%h required en=%b fin=%b ovf=%b addr=%h data=%h",
                 s, o_m1_wr_en, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data,
                 exp_en, exp_fin, exp_ovf, exp_addr, exp_data);
      end
      if (o_m1_wr_en === 1'b1) last_addr = o_m1_wr_addr;
      if (o_finish === 1'b1) fin_seen = 1;
    end
    total++;
    if (last_addr !== 32'd255 || !fin_seen || o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL full_chirp_end got last_addr=%0d fin=%b ovf=%b required 255 1 1",
               last_addr, fin_seen, o_overflow);
    end
    // Overflow is sticky through idle cycles and clears on i_start.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++;
    if (o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky got %b required 1", o_overflow);
    end
    cycle(1, 0, 0, 0);
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got %b required 0", o_overflow);
    end
  endtask

  task automatic test_restart();
    bit fin_seen;
    fin_seen = 0;
    cycle(1, 0, 0, 0);
    for (int s = 1; s <= 10; s++) begin
      // i_start arrives together with sample 9: it becomes lane 0 of the new chirp.
      cycle((s == 7), 1, (s == 10), (s <= 6) ? s : s + 2);
      total++;
      if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !==
          {exp_en, exp_en, exp_fin, exp_ovf, exp_addr, exp_data}) begin
        bad++;
        $display("FAIL restart s=%0d got en=%b fin=%b ovf=%b addr=%h data=%h required en=%b fin=%b ovf=%b addr=%h data=%h",
                 s, o_m1_wr_en, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data,
                 exp_en, exp_fin, exp_ovf, exp_addr, exp_data);
      end
      if (o_finish === 1'b1 && s < 10) fin_seen = 1;
    end
    total++;
    if (fin_seen || o_m1_wr_data !== {32'd12, 32'd11, 32'd10, 32'd9} || o_m1_wr_addr !== 32'd0) begin
      bad++;
      $display("FAIL restart_const got early_fin=%b addr=%h data=%h required 0 0 0000000c0000000b0000000a00000009",
               fin_seen, o_m1_wr_addr, o_m1_wr_data);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    for (int s = 1; s <= 3; s++) cycle(0, 1, 0, s);
    rst_n = 0;
    #2;
    model_reset();
    total++;
    if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !== {4'b0, 32'd0, 128'd0}) begin
      bad++;
      $display("FAIL reset_mid got en=%b fin=%b ovf=%b addr=%h data=%h required all zero",
               o_m1_wr_en, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int s = 0; s < 5; s++) begin
      cycle(0, 1, 0, 32'h50 + s);
      total++;
      if ({o_m1_wr_en, o_finish, o_overflow, o_m1_wr_data} !== {3'b0, 128'd0}) begin
        bad++;
        $display("FAIL reset_mid_idle s=%0d got en=%b fin=%b ovf=%b data=%h required 0",
                 s, o_m1_wr_en, o_finish, o_overflow, o_m1_wr_data);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3000; s++) begin
      bit st = ($urandom_range(0, 99) < 2);
      bit v  = ($urandom_range(0, 99) < 75);
      bit l  = v && ($urandom_range(0, 99) < 6);
      cycle(st, v, l, $urandom);
      total++;
      if ({o_m1_wr_en, o_m1_wr_wea, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data} !==
          {exp_en, exp_en, exp_fin, exp_ovf, exp_addr, exp_data}) begin
        bad++;
        $display("FAIL random s=%0d got en=%b fin=%b ovf=%b addr=%h data=%h required en=%b fin=%b ovf=%b addr=%h data=%h",
                 s, o_m1_wr_en, o_finish, o_overflow, o_m1_wr_addr, o_m1_wr_data,
                 exp_en, exp_fin, exp_ovf, exp_addr, exp_data);
      end
    end
  endtask

  initial begin
    n_writes = 0;
    test_reset();
    test_basic();
    test_full_chirp();
    test_restart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
